// File: rtl/iir_pkg.sv
// Shared widths and sample/coefficient types for the biquad IIR filter.
package iir_pkg;
  localparam int DATA_W    = 16;
  localparam int COEF_W    = 32;
  localparam int COEF_FRAC = 14;
  localparam int ACC_W     = 52;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;
endpackage

// File: rtl/iir_round_sat.sv
// Round-half-up and saturate a wide accumulator back to one output sample.
module iir_round_sat #(
  parameter int COEF_FRAC = iir_pkg::COEF_FRAC
) (
  input  logic signed [iir_pkg::ACC_W-1:0]  acc_i,
  output logic signed [iir_pkg::DATA_W-1:0] y_o
);
  import iir_pkg::*;

  localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(1) <<< (COEF_FRAC - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DATA_W - 1)));

  logic signed [ACC_W-1:0] shifted;

  // Adding one half before the arithmetic shift rounds ties towards +infinity.
  always_comb begin
    shifted = (acc_i + HALF) >>> COEF_FRAC;
    y_o     = shifted[DATA_W-1:0];
    if (shifted > SAT_MAX) begin
      y_o = {1'b0, {(DATA_W - 1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      y_o = {1'b1, {(DATA_W - 1){1'b0}}};
    end
  end
endmodule

// File: rtl/iir_filter_biquad.sv
// Direct Form I biquad: one sample per clock, rounded/saturated registered output.
module iir_filter_biquad #(
  parameter int COEF_FRAC = iir_pkg::COEF_FRAC,
  parameter int DATA_W    = iir_pkg::DATA_W,
  parameter int COEF_W    = iir_pkg::COEF_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic signed [COEF_W-1:0] b0,
  input  logic signed [COEF_W-1:0] b1,
  input  logic signed [COEF_W-1:0] b2,
  input  logic signed [COEF_W-1:0] a1,
  input  logic signed [COEF_W-1:0] a2,
  output logic signed [DATA_W-1:0] y_out
);
  import iir_pkg::*;

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [DATA_W-1:0] x1_q, x2_q, y1_q, y2_q;
  logic signed [DATA_W-1:0] y_d;
  logic signed [PROD_W-1:0] p_b0, p_b1, p_b2, p_a1, p_a2;
  logic signed [ACC_W-1:0]  acc;

  assign p_b0 = PROD_W'(x_in) * PROD_W'(b0);
  assign p_b1 = PROD_W'(x1_q) * PROD_W'(b1);
  assign p_b2 = PROD_W'(x2_q) * PROD_W'(b2);
  assign p_a1 = PROD_W'(y1_q) * PROD_W'(a1);
  assign p_a2 = PROD_W'(y2_q) * PROD_W'(a2);

  // Feedback terms are subtracted so normalized coefficient sets load as-is.
  assign acc = ACC_W'(p_b0) + ACC_W'(p_b1) + ACC_W'(p_b2)
             - ACC_W'(p_a1) - ACC_W'(p_a2);

  iir_round_sat #(
    .COEF_FRAC(COEF_FRAC)
  ) u_round_sat (
    .acc_i(acc),
    .y_o  (y_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x1_q <= '0;
      x2_q <= '0;
      y1_q <= '0;
      y2_q <= '0;
    end else begin
      x1_q <= x_in;
      x2_q <= x1_q;
      y1_q <= y_d;
      y2_q <= y1_q;
    end
  end

  // The newest output history register is the registered filter output.
  assign y_out = y1_q;
endmodule

// File: tb/tb_iir_filter_biquad.sv
// Self-checking bench for iir_filter_biquad against an arithmetic reference model.
module tb_iir_filter_biquad;
  import iir_pkg::*;

  logic    clk;
  logic    rst;
  sample_t x_in;
  coef_t   b0, b1, b2, a1, a2;
  sample_t y_out;

  int errors = 0;
  int checks = 0;

  longint cb0, cb1, cb2, ca1, ca2;
  longint mx1, mx2, my1, my2;

  iir_filter_biquad dut (
    .clk  (clk),
    .rst  (rst),
    .x_in (x_in),
    .b0   (b0),
    .b1   (b1),
    .b2   (b2),
    .a1   (a1),
    .a2   (a2),
    .y_out(y_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact difference equation, round half up by floor division, clamp.
  function automatic longint model_step(input longint x);
    longint acc, q;
    acc = cb0 * x + cb1 * mx1 + cb2 * mx2 - ca1 * my1 - ca2 * my2 + 8192;
    if (acc >= 0) q = acc / 16384;
    else          q = -((-acc + 16383) / 16384);
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    mx2 = mx1;
    mx1 = x;
    my2 = my1;
    my1 = q;
    return q;
  endfunction

  task automatic model_clear();
    mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
  endtask

  task automatic set_coefs(input int vb0, input int vb1, input int vb2,
                           input int va1, input int va2);
    b0 = vb0; b1 = vb1; b2 = vb2; a1 = va1; a2 = va2;
    cb0 = vb0; cb1 = vb1; cb2 = vb2; ca1 = va1; ca2 = va2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b0;
    x_in = '0;
    #2;
    rst = 1'b1;
    model_clear();
  endtask

  task automatic step(input int x);
    @(negedge clk);
    x_in = sample_t'(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (y_out !== 16'sd0) begin
      errors++;
      $display("[TB] FAIL reset_initial: y_out=%0d expected 0", y_out);
    end
  endtask

  task automatic test_passthrough();
    int xs[3] = '{1000, -2500, 32767};
    int prev;
    do_reset();
    set_coefs(16384, 0, 0, 0, 0);
    prev = 0;
    foreach (xs[i]) begin
      @(negedge clk);
      x_in = sample_t'(xs[i]);
      #1;
      checks++;
      if (y_out !== sample_t'(prev)) begin
        errors++;
        $display("[TB] FAIL passthrough_latency[%0d]: y_out=%0d expected %0d", i, y_out, prev);
      end
      @(posedge clk);
      #1;
      checks++;
      if (y_out !== sample_t'(xs[i])) begin
        errors++;
        $display("[TB] FAIL passthrough[%0d]: y_out=%0d expected %0d", i, y_out, xs[i]);
      end
      prev = xs[i];
    end
  endtask

  task automatic test_delay();
    int xs[4]  = '{1000, 0, 0, 0};
    int exp[4] = '{0, 1000, 0, 0};
    do_reset();
    set_coefs(0, 16384, 0, 0, 0);
    foreach (xs[i]) begin
      step(xs[i]);
      checks++;
      if (y_out !== sample_t'(exp[i])) begin
        errors++;
        $display("[TB] FAIL delay[%0d]: y_out=%0d expected %0d", i, y_out, exp[i]);
      end
    end
  endtask

  task automatic test_decay();
    int exp[6] = '{1000, 500, 250, 125, 63, 32};
    do_reset();
    set_coefs(16384, 0, 0, -8192, 0);
    foreach (exp[i]) begin
      step(i == 0 ? 1000 : 0);
      checks++;
      if (y_out !== sample_t'(exp[i])) begin
        errors++;
        $display("[TB] FAIL decay[%0d]: y_out=%0d expected %0d", i, y_out, exp[i]);
      end
    end
  endtask

  task automatic test_saturation();
    int cf[4]  = '{32768, 32768, 8192, 8192};
    int xs[4]  = '{20000, -20000, 3, -3};
    int exp[4] = '{32767, -32768, 2, -1};
    do_reset();
    foreach (xs[i]) begin
      set_coefs(cf[i], 0, 0, 0, 0);
      step(xs[i]);
      checks++;
      if (y_out !== sample_t'(exp[i])) begin
        errors++;
        $display("[TB] FAIL sat_round[%0d]: y_out=%0d expected %0d", i, y_out, exp[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    int exp[4] = '{1000, 500, 250, 125};
    do_reset();
    set_coefs(16384, 0, 0, -8192, 0);
    step(1000);
    step(0);
    step(0);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (y_out !== 16'sd0) begin
      errors++;
      $display("[TB] FAIL midstream_async: y_out=%0d expected 0", y_out);
    end
    x_in = 16'sd1234;
    @(posedge clk);
    #1;
    checks++;
    if (y_out !== 16'sd0) begin
      errors++;
      $display("[TB] FAIL midstream_held: y_out=%0d expected 0", y_out);
    end
    @(negedge clk);
    #1;
    x_in = 16'sd1000;
    rst  = 1'b1;
    foreach (exp[i]) begin
      if (i == 0) begin
        @(posedge clk);
        #1;
      end else begin
        step(0);
      end
      checks++;
      if (y_out !== sample_t'(exp[i])) begin
        errors++;
        $display("[TB] FAIL midstream_restart[%0d]: y_out=%0d expected %0d", i, y_out, exp[i]);
      end
    end
  endtask

  task automatic run_model_stream(input string name, input int n);
    int     x;
    longint exp;
    for (int i = 0; i < n; i++) begin
      x = int'($signed(16'($urandom)));
      if (i % 4 == 0) x = x / 8;
      exp = model_step(longint'(x));
      step(x);
      checks++;
      if (y_out !== sample_t'(exp)) begin
        errors++;
        $display("[TB] FAIL %s[%0d]: x=%0d y_out=%0d expected %0d", name, i, x, y_out, exp);
      end
    end
  endtask

  task automatic test_lowpass_model();
    do_reset();
    set_coefs(1106, 2212, 1106, -18727, 6763);
    run_model_stream("lowpass", 100);
  endtask

  task automatic test_random_coefs();
    do_reset();
    set_coefs(int'($urandom_range(0, 65536)) - 32768, int'($urandom_range(0, 65536)) - 32768,
              int'($urandom_range(0, 65536)) - 32768, int'($urandom_range(0, 32768)) - 16384,
              int'($urandom_range(0, 16384)) - 8192);
    run_model_stream("randcoef", 40);
  endtask

  initial begin
    rst  = 1'b0;
    x_in = '0;
    set_coefs(0, 0, 0, 0, 0);
    model_clear();
    #1;
    test_reset();
    #2;
    rst = 1'b1;
    test_passthrough();
    test_delay();
    test_decay();
    test_saturation();
    test_reset_midstream();
    test_lowpass_model();
    test_random_coefs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
